// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag-index and legality helpers shared by the ALU and its issue stage
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0111,
    OP_SRA = 4'b1000,
    OP_ROL = 4'b1001,
    OP_ROR = 4'b1010,
    OP_EQ  = 4'b1011,
    OP_LT  = 4'b1100
  } alu_op_e;

  localparam logic [3:0] OP_LAST = 4'b1100;

  // Bit positions inside res_flags = {carry, ovf, neg, zero}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 3;

  function automatic logic op_is_illegal(input logic [3:0] sel);
    return sel > OP_LAST;
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// rtl/alu_issue_fifo.sv - synchronous command FIFO feeding the ALU issue stage
module alu_issue_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 20,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop frees a slot on the same edge
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO plus result register around the combinational ALU
// Optional sticky {carry, ovf} accumulator enabled by ALU_ISSUE_STICKY_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_sel,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             alu_neg,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [3:0]       res_flags,
  output logic             res_illegal,
  output logic [LW-1:0]    fifo_level
`ifdef ALU_ISSUE_STICKY_EN
  ,
  input  logic             sticky_clr,
  output logic [1:0]       sticky_flags
`endif
);

  localparam int DATA_W = 4 + 2 * WIDTH;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty, push, pop;

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [3:0]       res_flags_q, res_flags_d;
  logic             res_illegal_q, res_illegal_d;

  alu_issue_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({cmd_sel, cmd_a, cmd_b}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !fifo_empty && (!res_valid_q || res_ready);

  // Idle ALU inputs are forced to zero so nothing stale toggles downstream
  assign {alu_sel, alu_a, alu_b} = fifo_empty ? '0 : fifo_head;

  always_comb begin
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_flags_d   = res_flags_q;
    res_illegal_d = res_illegal_q;
    if (pop) begin
      res_valid_d             = 1'b1;
      res_data_d              = alu_out;
      res_flags_d[FLAG_CARRY] = alu_carry;
      res_flags_d[FLAG_OVF]   = alu_ovf;
      res_flags_d[FLAG_NEG]   = alu_neg;
      res_flags_d[FLAG_ZERO]  = alu_zero;
      res_illegal_d           = op_is_illegal(alu_sel);
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_flags_q   <= '0;
      res_illegal_q <= 1'b0;
    end else begin
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_flags_q   <= res_flags_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_flags   = res_flags_q;
  assign res_illegal = res_illegal_q;

`ifdef ALU_ISSUE_STICKY_EN
  logic [1:0] sticky_q, sticky_d;

  // A clear on the same edge as a capture discards that capture's flags
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) sticky_d = '0;
    else if (pop)   sticky_d = sticky_q | {alu_carry, alu_ovf};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage with a behavioural ALU
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0, cmd_ready;
  logic [3:0]       cmd_sel = '0;
  logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [3:0]       alu_sel;
  logic             alu_carry, alu_zero, alu_ovf, alu_neg;
  logic             res_valid, res_ready = 1'b1, res_illegal;
  logic [WIDTH-1:0] res_data;
  logic [3:0]       res_flags;
  logic [LW-1:0]    fifo_level;
`ifdef ALU_ISSUE_STICKY_EN
  logic             sticky_clr = 1'b0;
  logic [1:0]       sticky_flags;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_sel     (cmd_sel),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_carry   (alu_carry),
    .alu_zero    (alu_zero),
    .alu_ovf     (alu_ovf),
    .alu_neg     (alu_neg),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_flags   (res_flags),
    .res_illegal (res_illegal),
    .fifo_level  (fifo_level)
`ifdef ALU_ISSUE_STICKY_EN
    ,
    .sticky_clr  (sticky_clr),
    .sticky_flags(sticky_flags)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [3:0]       flags;
    logic             ill;
  } res_t;

  // Reference ALU: flags packed {carry, ovf, neg, zero}, carry on SUB is borrow
  function automatic res_t alu_model(input logic [3:0] sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] w;
    logic           c, o;
    res_t           r;
    w = '0; c = 1'b0; o = 1'b0;
    case (sel)
      4'b0000: begin
        w = {1'b0, a} + {1'b0, b};
        c = w[WIDTH];
        o = (a[WIDTH-1] == b[WIDTH-1]) && (w[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        w = {1'b0, a} - {1'b0, b};
        c = w[WIDTH];
        o = (a[WIDTH-1] != b[WIDTH-1]) && (w[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: w = {1'b0, a & b};
      4'b0011: w = {1'b0, a | b};
      4'b0100: w = {1'b0, a ^ b};
      4'b1100: w = (a < b) ? (WIDTH+1)'(1) : '0;
      default: w = (sel > 4'b1100) ? '0 : {1'b0, a};
    endcase
    r.data  = w[WIDTH-1:0];
    r.flags = {c, o, r.data[WIDTH-1], r.data == '0};
    r.ill   = sel > 4'b1100;
    return r;
  endfunction

  res_t alu_now;
  always_comb begin
    alu_now   = alu_model(alu_sel, alu_a, alu_b);
    alu_out   = alu_now.data;
    alu_carry = alu_now.flags[3];
    alu_ovf   = alu_now.flags[2];
    alu_neg   = alu_now.flags[1];
    alu_zero  = alu_now.flags[0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b;
  endtask

  typedef struct {
    logic [3:0]       sel;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] exp_data;
    logic [3:0]       exp_flags;
    logic             exp_ill;
  } vec_t;

  vec_t vecs[8];
  res_t exp_q[$];
  res_t got, exp;

  initial begin
    vecs[0] = '{4'b0000, 8'hFF, 8'h01, 8'h00, 4'b1001, 1'b0};
    vecs[1] = '{4'b0001, 8'h80, 8'h01, 8'h7F, 4'b0100, 1'b0};
    vecs[2] = '{4'b0010, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0};
    vecs[3] = '{4'b0100, 8'h55, 8'hAA, 8'hFF, 4'b0010, 1'b0};
    vecs[4] = '{4'b1111, 8'h12, 8'h34, 8'h00, 4'b0001, 1'b1};
    vecs[5] = '{4'b0011, 8'h01, 8'h80, 8'h81, 4'b0010, 1'b0};
    vecs[6] = '{4'b0000, 8'h7F, 8'h01, 8'h80, 4'b0110, 1'b0};
    vecs[7] = '{4'b0001, 8'h00, 8'h01, 8'hFF, 4'b1010, 1'b0};

    #1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_data", 32'(res_data), 32'd0);
    check("reset_res_flags", 32'(res_flags), 32'd0);
    check("reset_fifo_level", 32'(fifo_level), 32'd0);
    #21 rst_n = 1'b1;
    tick();

    // Single commands: push, capture one edge later, then take with FIFO empty
    for (int i = 0; i < 8; i++) begin
      drive_cmd(vecs[i].sel, vecs[i].a, vecs[i].b);
      tick();
      cmd_valid = 1'b0;
      check($sformatf("vec%0d_pending", i), 32'(res_valid), 32'd0);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(res_valid), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(res_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_flags", i), 32'(res_flags), 32'(vecs[i].exp_flags));
      check($sformatf("vec%0d_illegal", i), 32'(res_illegal), 32'(vecs[i].exp_ill));
      tick();
      check($sformatf("vec%0d_taken", i), 32'(res_valid), 32'd0);
      check($sformatf("vec%0d_hold", i), 32'(res_data), 32'(vecs[i].exp_data));
    end

`ifdef ALU_ISSUE_STICKY_EN
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_cleared", 32'(sticky_flags), 32'd0);
    drive_cmd(4'b0000, 8'hFF, 8'h01);
    tick();
    drive_cmd(4'b0010, 8'h0F, 8'hF0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("sticky_persist", 32'(sticky_flags), 32'b10);
    drive_cmd(4'b0000, 8'h7F, 8'h01);
    tick();
    cmd_valid = 1'b0;
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_clr_wins_valid", 32'(res_valid), 32'd1);
    check("sticky_clr_wins", 32'(sticky_flags), 32'b00);
    tick();
`endif

    // Burst into a stalled consumer: DEPTH+1 accepted, then backpressure
    begin
      int         accepted;
      logic [3:0] sels[6];
      sels = '{4'b0000, 4'b0001, 4'b0100, 4'b1111, 4'b0010, 4'b0011};
      accepted = 0;
      res_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
        drive_cmd(sels[i], 8'($urandom), 8'($urandom));
        if (cmd_ready) begin
          accepted++;
          exp_q.push_back(alu_model(cmd_sel, cmd_a, cmd_b));
        end
        tick();
      end
      check("burst_accepted", 32'(accepted), 32'd5);
      check("burst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("burst_level", 32'(fifo_level), 32'd4);
      cmd_valid = 1'b0;
    end

    begin
      int taken, cycles;
      taken = 0; cycles = 0;
      res_ready = 1'b1;
      while ((exp_q.size() != 0 || res_valid) && cycles < 30) begin
        if (res_valid) begin
          got = {res_data, res_flags, res_illegal};
          if (exp_q.size() == 0) begin
            check("drain_extra_result", 32'(res_valid), 32'd0);
          end else begin
            exp = exp_q.pop_front();
            check($sformatf("drain%0d_result", taken), 32'(got), 32'(exp));
          end
          taken++;
        end
        cycles++;
        tick();
      end
      check("drain_count", 32'(taken), 32'd5);
      check("drain_back_to_back", 32'(cycles), 32'd5);
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Reset with three commands queued and a result pending
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(4'b0000, 8'(i + 1), 8'h10);
      tick();
    end
    cmd_valid = 1'b0;
    check("prereset_level", 32'(fifo_level), 32'd3);
    check("prereset_valid", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midreset_res_valid", 32'(res_valid), 32'd0);
    check("midreset_res_data", 32'(res_data), 32'd0);
    check("midreset_res_flags", 32'(res_flags), 32'd0);
    check("midreset_illegal", 32'(res_illegal), 32'd0);
    check("midreset_level", 32'(fifo_level), 32'd0);
    check("midreset_alu_sel", 32'({alu_sel, alu_a, alu_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("postreset%0d_no_stale", i), 32'({res_valid, fifo_level}), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
